// File: rtl/multicycle_addsub.sv
// Sequential adder/subtractor resolving CHUNK bits per cycle over WIDTH/CHUNK cycles.
// Optional zero/negative result flags are enabled by defining MULTICYCLE_ADDSUB_FLAGS_EN.
//
// state  | meaning
// S_IDLE | waiting for an operation, in_ready=1, last result held
// S_RUN  | adding one chunk per cycle, lowest chunk first
// S_DONE | result presented with out_valid=1 until out_ready
module multicycle_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carryin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
`ifdef MULTICYCLE_ADDSUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             negative
`endif
);

  localparam int NCHUNK = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (CHUNK < 1) begin : g_chk_chunk
      $error("multicycle_addsub: CHUNK must be at least 1");
    end else if (WIDTH % CHUNK != 0) begin : g_chk_div
      $error("multicycle_addsub: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_carryout;
  logic             r_overflow;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_add;
  logic             w_last;
  logic             w_msb_cin;

  // Operands shift right each cycle so the active chunk is always the low slice.
  assign w_a_chunk = r_a[CHUNK-1:0];
  assign w_b_chunk = r_b[CHUNK-1:0];
  assign w_add     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
  assign w_last    = (r_cnt == '0);
  // Carry into the MSB recovered from the MSB's own sum bit.
  assign w_msb_cin = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_add[CHUNK-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_sum      <= '0;
      r_carryout <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= sub | carryin;
            r_cnt   <= CNT_W'(NCHUNK - 1);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_add[CHUNK];
          for (int j = 0; j < NCHUNK; j++) begin
            if (r_cnt == CNT_W'(NCHUNK - 1 - j)) begin
              r_sum[j*CHUNK +: CHUNK] <= w_add[CHUNK-1:0];
            end
          end
          if (w_last) begin
            r_carryout <= w_add[CHUNK];
            r_overflow <= w_add[CHUNK] ^ w_msb_cin;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign carryout  = r_carryout;
  assign overflow  = r_overflow;

`ifdef MULTICYCLE_ADDSUB_FLAGS_EN
  logic r_any_nz;
  logic r_zero;
  logic r_negative;

  // Zero is accumulated chunk by chunk so no full-width compare is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_any_nz   <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_any_nz <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_any_nz <= r_any_nz | (|w_add[CHUNK-1:0]);
      if (w_last) begin
        r_zero     <= ~(r_any_nz | (|w_add[CHUNK-1:0]));
        r_negative <= w_add[CHUNK-1];
      end
    end
  end

  assign zero     = r_zero;
  assign negative = r_negative;
`endif

endmodule

// File: tb/tb_multicycle_addsub.sv
// Scoreboard bench for multicycle_addsub (32/8): directed cases, randomized ops,
// backpressure and reset-mid-run, against a plain-arithmetic reference model.
module tb_multicycle_addsub;

  localparam int W  = 32;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sub;
  logic          carryin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          carryout;
  logic          overflow;
`ifdef MULTICYCLE_ADDSUB_FLAGS_EN
  logic          zero;
  logic          negative;
`endif

  multicycle_addsub #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .carryin   (carryin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carryout  (carryout),
    .overflow  (overflow)
`ifdef MULTICYCLE_ADDSUB_FLAGS_EN
    ,
    .zero      (zero),
    .negative  (negative)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input logic ci);
    exp_t   e;
    longint sx;
    longint sy;
    longint r;
    logic [W:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      r   = sx - sy;
      u   = {1'b0, x} - {1'b0, y};
      e.c = (x >= y);
    end else begin
      r   = sx + sy + longint'(ci);
      u   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      e.c = u[W];
    end
    e.s = u[W-1:0];
    e.v = (r > MAXS) || (r < MINS);
    e.z = (e.s == '0);
    e.n = e.s[W-1];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whenever a result is handed over.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(sum), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", 64'(sum), 64'(e.s));
        chk("carryout", 64'(carryout), 64'(e.c));
        chk("overflow", 64'(overflow), 64'(e.v));
`ifdef MULTICYCLE_ADDSUB_FLAGS_EN
        chk("zero", 64'(zero), 64'(e.z));
        chk("negative", 64'(negative), 64'(e.n));
`endif
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic ci, input int hold);
    exp_t e;
    int   cyc;
    e = model(x, y, s, ci);
    chk("in_ready_before", 64'(in_ready), 64'd1);
    a = x; b = y; sub = s; carryin = ci; in_valid = 1'b1;
    sb.push_back(e);
    tick();
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      in_valid = 1'($urandom);
      a = $urandom; b = $urandom; sub = 1'($urandom); carryin = 1'($urandom);
      tick();
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(NC));
    for (int k = 0; k < hold; k++) begin
      chk("hold_sum", 64'(sum), 64'(e.s));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      in_valid = 1'($urandom);
      a = $urandom; b = $urandom;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_sum_kept", 64'(sum), 64'(e.s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; carryin = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_carryout", 64'(carryout), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
`ifdef MULTICYCLE_ADDSUB_FLAGS_EN
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_negative", 64'(negative), 64'd0);
`endif

    run_op(32'd20, 32'd40, 1'b0, 1'b1, 0);
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1);
    run_op(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 0);
    run_op(32'd10, 32'd20, 1'b1, 1'b1, 2);
    run_op(32'h80000000, 32'd1, 1'b1, 1'b0, 5);
    run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 0);
    run_op(32'd5, 32'd5, 1'b1, 1'b0, 0);
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = $urandom;
      y = $urandom;
      if (i % 8 == 0) y = ~x;
      run_op(x, y, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset during RUN drops the operation.
    a = 32'h12345678; b = 32'h11111111; sub = 1'b0; carryin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrun_in_ready", 64'(in_ready), 64'd1);
    chk("midrun_out_valid", 64'(out_valid), 64'd0);
    chk("midrun_sum", 64'(sum), 64'd0);
    chk("midrun_carryout", 64'(carryout), 64'd0);
    run_op(32'd2, 32'd4, 1'b0, 1'b1, 0);

    repeat (2) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
